interrupt_scheduler: RTL and testbench
======================================

# interrupt_scheduler

Prioritised interrupt and time-slice scheduler for the single-cycle CPU. It owns the quantum timer and latches halt, timer and keyboard events. When an event wins, it redirects the PC to the kernel vector and saves the interrupted PC. It also serves the cause code to the control unit, replacing the ad-hoc `qualInterrupcao`/`bufferPC` logic with one sequenced block between the control unit, the PC and the `MultiplexadorPC` path.

## Interface
Parameters:
- PC_WIDTH, 11, width of instruction addresses
- QUANTUM_WIDTH, 16, width of the timer quantum (matches Instrucao[15:0])
- VECTOR_PC, 0, kernel entry address driven on redirect

Ports:
- Clock  in  1  CPU clock; single clock domain
- Reset  in  1  synchronous, active-high reset
- halt_req  in  1  Halt from UnidadeControle; a process ended
- kbd_req  in  1  one-cycle pulse, PS/2 byte ready
- set_quantum  in  1  setClock; load quantum_value
- quantum_value  in  QUANTUM_WIDTH  new quantum; 0 disarms the timer
- int_return  in  1  kernel finished the handler; unmask
- get_cause  in  1  getInterruption; consume the cause code
- pc_next  in  PC_WIDTH  PC the CPU would load this cycle (jump/branch mux output)
- take_int  out  1  force the PC to vector_pc this cycle
- vector_pc  out  PC_WIDTH  constant VECTOR_PC
- saved_pc  out  PC_WIDTH  PC of the interrupted instruction stream
- cause  out  32  0 none, 1 timer, 2 halt, 3 keyboard
- pending  out  3  latched events {kbd, halt, timer}
- timer_armed  out  1  quantum timer running

## Operation
- State machine RUN -> TAKE -> HANDLER -> RUN.
- RUN:
  - Events set pending bits.
  - If any pending bit is set at a clock edge, go to TAKE.
- TAKE, exactly one cycle:
  - take_int=1.
  - At the closing edge: saved_pc<=pc_next; cause<=code of the highest-priority pending bit; clear that bit only; go to HANDLER.
- HANDLER:
  - All events are still latched into pending; none are taken.
  - int_return -> RUN. If pending≠0, the CPU enters TAKE on the following edge.
- Priority: halt(2) > timer(1) > keyboard(3).
- get_cause: cause clears to 0 at the next edge, unless TAKE writes a new cause on that same edge, in which case the new cause wins.
- Timer:
  - set_quantum loads counter and reload register with quantum_value; timer_armed=(quantum_value≠0).
  - The counter decrements by 1 per cycle only in RUN while armed.
  - When counter==1 and decrementing: set pending.timer and reload the counter from the reload register (auto-reload).
  - The counter is frozen in TAKE and HANDLER, so kernel time is not charged to the process.
- Simultaneous events:
  - set_quantum on an expiry cycle: the load wins; the expiry is dropped.
  - An event on the same cycle as int_return is pended and taken via TAKE next.
  - An event arriving for an already-pending bit merges; no count is kept.
- Arithmetic: the counter is unsigned QUANTUM_WIDTH and never wraps below 1 while armed.
- Reset mid-operation: every state, counter and pending bit returns to its reset value; a redirect in progress is abandoned.

## Timing
- Reset values: state=RUN, take_int=0, saved_pc=0, cause=0, pending=0, timer_armed=0, counter=0, reload=0.
- Event latency:
  - An event sampled at edge N gives pending=1 after N.
  - TAKE (take_int=1) runs during cycle N+1.
  - saved_pc and cause update at edge N+2.
- take_int is a registered state decode, so there is no combinational path from the inputs.
- Quantum Q loaded at edge L, with no interrupts: pending.timer sets at edge L+Q; take_int is asserted in the cycle after.
- Outputs are stable for the whole cycle; everything changes only on the rising edge of Clock.

## Test plan
- Reset, then idle for 10 cycles -> all outputs stay 0; timer_armed=0.
- set_quantum with quantum_value=5, pc_next=0x020 -> take_int high exactly 1 cycle, 6 cycles after the load. saved_pc=0x020, cause=1. The counter re-arms with 5 after int_return.
- halt_req and kbd_req on the same cycle -> cause=2 taken first. pending=3'b100 stays through HANDLER. After int_return, TAKE repeats with cause=3.
- In HANDLER, pulse kbd_req, and hold 20 cycles with quantum 3 armed -> no take_int; the counter does not change; pending.kbd=1 until int_return.
- get_cause while cause=1 -> cause=0 next edge. get_cause on the TAKE edge of a halt -> cause=2.
- set_quantum with quantum_value=0 on the expiry cycle -> no timer pending; timer_armed=0. Assert Reset during TAKE -> take_int=0 next cycle, state RUN.

Source files
------------

// File: rtl/interrupt_scheduler.sv
// Prioritised interrupt and time-slice scheduler: latches halt/timer/keyboard
// events, redirects the PC to the kernel vector and owns the quantum timer.
module interrupt_scheduler #(
    parameter int unsigned PC_WIDTH      = 11,
    parameter int unsigned QUANTUM_WIDTH = 16,
    parameter int unsigned VECTOR_PC     = 0
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     halt_req,
    input  logic                     kbd_req,
    input  logic                     set_quantum,
    input  logic [QUANTUM_WIDTH-1:0] quantum_value,
    input  logic                     int_return,
    input  logic                     get_cause,
    input  logic [PC_WIDTH-1:0]      pc_next,
    output logic                     take_int,
    output logic [PC_WIDTH-1:0]      vector_pc,
    output logic [PC_WIDTH-1:0]      saved_pc,
    output logic [31:0]              cause,
    output logic [2:0]               pending,
    output logic                     timer_armed
);

    localparam logic [1:0] CAUSE_TIMER = 2'd1;
    localparam logic [1:0] CAUSE_HALT  = 2'd2;
    localparam logic [1:0] CAUSE_KBD   = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [QUANTUM_WIDTH-1:0] count;
    logic [QUANTUM_WIDTH-1:0] count_next;
    logic [QUANTUM_WIDTH-1:0] reload;
    logic                     expire;
    logic [1:0]               take_code;
    logic [2:0]               take_mask;
    logic [2:0]               clear_mask;
    logic [2:0]               events;

    assign vector_pc = PC_WIDTH'(VECTOR_PC);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:     if (|pending) state_next = ST_TAKE;
            ST_TAKE:    state_next = ST_HANDLER;
            ST_HANDLER: if (int_return) state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    // Priority select over {kbd, halt, timer}: halt > timer > kbd
    always_comb begin
        take_code = 2'd0;
        take_mask = 3'b000;
        if (pending[1]) begin
            take_code = CAUSE_HALT;
            take_mask = 3'b010;
        end else if (pending[0]) begin
            take_code = CAUSE_TIMER;
            take_mask = 3'b001;
        end else if (pending[2]) begin
            take_code = CAUSE_KBD;
            take_mask = 3'b100;
        end
        clear_mask = (state == ST_TAKE) ? take_mask : 3'b000;
    end

    // Quantum timer: a load overrides any expiry; counting only while running user code
    always_comb begin
        count_next = count;
        expire     = 1'b0;
        if (set_quantum) begin
            count_next = quantum_value;
        end else if ((state == ST_RUN) && timer_armed) begin
            if (count == QUANTUM_WIDTH'(1)) begin
                count_next = reload;
                expire     = 1'b1;
            end else begin
                count_next = count - QUANTUM_WIDTH'(1);
            end
        end
        events = {kbd_req, halt_req, expire};
    end

    // Registered outputs and timer state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            take_int    <= 1'b0;
            saved_pc    <= '0;
            cause       <= '0;
            pending     <= '0;
            timer_armed <= 1'b0;
            count       <= '0;
            reload      <= '0;
        end else begin
            take_int <= (state_next == ST_TAKE);
            pending  <= (pending & ~clear_mask) | events;
            count    <= count_next;
            if (set_quantum) begin
                reload      <= quantum_value;
                timer_armed <= (quantum_value != '0);
            end
            // A cause written by TAKE takes precedence over a concurrent consume
            if (state == ST_TAKE) begin
                saved_pc <= pc_next;
                cause    <= 32'(take_code);
            end else if (get_cause) begin
                cause <= '0;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Directed self-checking bench for interrupt_scheduler.
module tb_interrupt_scheduler;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        halt_req = 1'b0;
    logic        kbd_req = 1'b0;
    logic        set_quantum = 1'b0;
    logic [15:0] quantum_value = 16'd0;
    logic        int_return = 1'b0;
    logic        get_cause = 1'b0;
    logic [10:0] pc_next = 11'd0;
    logic        take_int;
    logic [10:0] vector_pc;
    logic [10:0] saved_pc;
    logic [31:0] cause;
    logic [2:0]  pending;
    logic        timer_armed;

    int checks = 0;
    int failures = 0;

    interrupt_scheduler #(
        .PC_WIDTH(11),
        .QUANTUM_WIDTH(16),
        .VECTOR_PC(0)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .halt_req(halt_req),
        .kbd_req(kbd_req),
        .set_quantum(set_quantum),
        .quantum_value(quantum_value),
        .int_return(int_return),
        .get_cause(get_cause),
        .pc_next(pc_next),
        .take_int(take_int),
        .vector_pc(vector_pc),
        .saved_pc(saved_pc),
        .cause(cause),
        .pending(pending),
        .timer_armed(timer_armed)
    );

    always #5 Clock = ~Clock;

    // Inputs and samples both happen 1 time unit after a rising edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (take_int !== 1'b0 || timer_armed !== 1'b0 || pending !== 3'b000 ||
                cause !== 32'd0 || saved_pc !== 11'd0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got take=%0b armed=%0b pend=%b cause=%0d spc=%0h exp all 0",
                         i, take_int, timer_armed, pending, cause, saved_pc);
            end
        end
        checks++;
        if (vector_pc !== 11'd0) begin
            failures++;
            $display("FAIL vector_pc got=%0h exp=0", vector_pc);
        end
    endtask

    task automatic test_timer();
        int first_take;
        int highs;
        bit found;
        pc_next = 11'h020;
        quantum_value = 16'd5;
        set_quantum = 1'b1;
        tick();
        set_quantum = 1'b0;
        checks++;
        if (timer_armed !== 1'b1) begin
            failures++;
            $display("FAIL timer_armed_q5 got=%0b exp=1", timer_armed);
        end
        first_take = -1;
        highs = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) begin
                checks++;
                if (pending !== 3'b001) begin
                    failures++;
                    $display("FAIL timer_pending_at_q got=%b exp=001", pending);
                end
            end
            if (take_int === 1'b1) begin
                highs++;
                if (first_take < 0) first_take = i;
            end
        end
        checks++;
        if (first_take != 6 || highs != 1) begin
            failures++;
            $display("FAIL timer_take_timing got first=%0d count=%0d exp first=6 count=1", first_take, highs);
        end
        checks++;
        if (saved_pc !== 11'h020 || cause !== 32'd1 || pending !== 3'b000) begin
            failures++;
            $display("FAIL timer_handler got spc=%0h cause=%0d pend=%b exp spc=20 cause=1 pend=000",
                     saved_pc, cause, pending);
        end
        get_cause = 1'b1;
        tick();
        get_cause = 1'b0;
        checks++;
        if (cause !== 32'd0) begin
            failures++;
            $display("FAIL get_cause_clear got=%0d exp=0", cause);
        end
        int_return = 1'b1;
        tick();
        int_return = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (take_int === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL timer_rearm got=no take exp=take within 10 cycles");
        end
        tick();
        checks++;
        if (cause !== 32'd1 || take_int !== 1'b0) begin
            failures++;
            $display("FAIL timer_rearm_cause got cause=%0d take=%0b exp cause=1 take=0", cause, take_int);
        end
        quantum_value = 16'd0;
        set_quantum = 1'b1;
        int_return = 1'b1;
        tick();
        set_quantum = 1'b0;
        int_return = 1'b0;
        checks++;
        if (timer_armed !== 1'b0 || pending !== 3'b000) begin
            failures++;
            $display("FAIL timer_disarm got armed=%0b pend=%b exp armed=0 pend=000", timer_armed, pending);
        end
    endtask

    task automatic test_priority();
        int bad;
        pc_next = 11'h155;
        halt_req = 1'b1;
        kbd_req = 1'b1;
        tick();
        halt_req = 1'b0;
        kbd_req = 1'b0;
        checks++;
        if (pending !== 3'b110 || take_int !== 1'b0) begin
            failures++;
            $display("FAIL prio_latch got pend=%b take=%0b exp pend=110 take=0", pending, take_int);
        end
        tick();
        checks++;
        if (take_int !== 1'b1) begin
            failures++;
            $display("FAIL prio_take1 got=%0b exp=1", take_int);
        end
        tick();
        checks++;
        if (cause !== 32'd2 || saved_pc !== 11'h155 || pending !== 3'b100 || take_int !== 1'b0) begin
            failures++;
            $display("FAIL prio_halt_first got cause=%0d spc=%0h pend=%b take=%0b exp 2 155 100 0",
                     cause, saved_pc, pending, take_int);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (take_int !== 1'b0 || pending !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL prio_handler_hold got bad_cycles=%0d exp=0", bad);
        end
        pc_next = 11'h0AA;
        int_return = 1'b1;
        tick();
        int_return = 1'b0;
        tick();
        checks++;
        if (take_int !== 1'b1) begin
            failures++;
            $display("FAIL prio_take2 got=%0b exp=1", take_int);
        end
        tick();
        checks++;
        if (cause !== 32'd3 || saved_pc !== 11'h0AA || pending !== 3'b000) begin
            failures++;
            $display("FAIL prio_kbd_second got cause=%0d spc=%0h pend=%b exp 3 aa 000", cause, saved_pc, pending);
        end
        int_return = 1'b1;
        tick();
        int_return = 1'b0;
    endtask

    task automatic test_handler_freeze();
        int bad;
        bit found;
        pc_next = 11'h300;
        quantum_value = 16'd3;
        set_quantum = 1'b1;
        tick();
        set_quantum = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (take_int === 1'b1) found = 1'b1;
        end
        tick();
        checks++;
        if (!found || cause !== 32'd1) begin
            failures++;
            $display("FAIL freeze_entry got found=%0b cause=%0d exp found=1 cause=1", found, cause);
        end
        kbd_req = 1'b1;
        tick();
        kbd_req = 1'b0;
        // A running counter would expire within 20 cycles and set pending.timer
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (take_int !== 1'b0 || pending !== 3'b100 || timer_armed !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL freeze_hold got bad_cycles=%0d exp=0", bad);
        end
        int_return = 1'b1;
        tick();
        int_return = 1'b0;
        tick();
        checks++;
        if (take_int !== 1'b1) begin
            failures++;
            $display("FAIL freeze_kbd_take got=%0b exp=1", take_int);
        end
        tick();
        checks++;
        if (cause !== 32'd3 || pending !== 3'b000) begin
            failures++;
            $display("FAIL freeze_kbd_cause got cause=%0d pend=%b exp 3 000", cause, pending);
        end
        quantum_value = 16'd0;
        set_quantum = 1'b1;
        int_return = 1'b1;
        tick();
        set_quantum = 1'b0;
        int_return = 1'b0;
    endtask

    task automatic test_back_to_back();
        pc_next = 11'h1FF;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        checks++;
        if (take_int !== 1'b1) begin
            failures++;
            $display("FAIL b2b_take got=%0b exp=1", take_int);
        end
        get_cause = 1'b1;
        tick();
        get_cause = 1'b0;
        checks++;
        if (cause !== 32'd2 || saved_pc !== 11'h1FF) begin
            failures++;
            $display("FAIL cause_on_take_edge got cause=%0d spc=%0h exp 2 1ff", cause, saved_pc);
        end
        int_return = 1'b1;
        kbd_req = 1'b1;
        tick();
        int_return = 1'b0;
        kbd_req = 1'b0;
        checks++;
        if (pending !== 3'b100 || take_int !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pend_on_return got pend=%b take=%0b exp 100 0", pending, take_int);
        end
        tick();
        checks++;
        if (take_int !== 1'b1) begin
            failures++;
            $display("FAIL b2b_retake got=%0b exp=1", take_int);
        end
        tick();
        checks++;
        if (cause !== 32'd3) begin
            failures++;
            $display("FAIL b2b_cause got=%0d exp=3", cause);
        end
        int_return = 1'b1;
        tick();
        int_return = 1'b0;
    endtask

    task automatic test_quantum_zero_on_expiry();
        int bad;
        quantum_value = 16'd4;
        set_quantum = 1'b1;
        tick();
        set_quantum = 1'b0;
        tick();
        tick();
        tick();
        quantum_value = 16'd0;
        set_quantum = 1'b1;
        tick();
        set_quantum = 1'b0;
        checks++;
        if (timer_armed !== 1'b0 || pending !== 3'b000) begin
            failures++;
            $display("FAIL q0_on_expiry got armed=%0b pend=%b exp 0 000", timer_armed, pending);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (take_int !== 1'b0 || pending !== 3'b000) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL q0_quiet got bad_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_during_take();
        int bad;
        pc_next = 11'h321;
        quantum_value = 16'd7;
        set_quantum = 1'b1;
        halt_req = 1'b1;
        tick();
        set_quantum = 1'b0;
        halt_req = 1'b0;
        tick();
        checks++;
        if (take_int !== 1'b1 || timer_armed !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_take got take=%0b armed=%0b exp 1 1", take_int, timer_armed);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (take_int !== 1'b0 || pending !== 3'b000 || cause !== 32'd0 ||
            saved_pc !== 11'd0 || timer_armed !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_take got take=%0b pend=%b cause=%0d spc=%0h armed=%0b exp all 0",
                     take_int, pending, cause, saved_pc, timer_armed);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (take_int !== 1'b0 || pending !== 3'b000) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_post_quiet got bad_cycles=%0d exp=0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_priority();
        test_handler_freeze();
        test_back_to_back();
        test_quantum_zero_on_expiry();
        test_reset_during_take();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
